// File: rtl/dac_spi_serializer.sv
// Serializes one held sample per accepted ZOH tick into an MSB-first frame for a 16-bit SPI DAC.
// The frame period is 1 + 2*SCLK_DIV*DATA_W + MIN_CS_HIGH clock cycles.
module dac_spi_serializer #(
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned SCLK_DIV      = 2,
  parameter int unsigned MIN_CS_HIGH   = 2,
  parameter bit          OFFSET_BINARY = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_sample_in,
  input  logic              i_tick,
  input  logic              i_clr_overrun,
  output logic              o_sclk,
  output logic              o_sdata,
  output logic              o_cs_n,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overrun
);

  localparam int unsigned BitPer = 2 * SCLK_DIV;
  localparam int unsigned DivW   = $clog2(BitPer);
  localparam int unsigned BitW   = $clog2(DATA_W);
  localparam int unsigned GapW   = $clog2(MIN_CS_HIGH + 1);

  localparam logic [DivW-1:0] DivLast = DivW'(BitPer - 1);
  localparam logic [DivW-1:0] DivHi   = DivW'(SCLK_DIV - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_W - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(MIN_CS_HIGH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e              r_state, w_state_d;
  logic [DivW-1:0]     r_div, w_div_d;
  logic [BitW-1:0]     r_bit, w_bit_d;
  logic [GapW-1:0]     r_gap, w_gap_d;
  logic [DATA_W-1:0]   r_shift, w_shift_d;
  logic                r_sclk, w_sclk_d;
  logic                r_cs_n, w_cs_n_d;
  logic                r_busy, w_busy_d;
  logic                r_done, w_done_d;
  logic                r_overrun, w_overrun_d;
  logic [DATA_W-1:0]   w_code;

  // Offset binary is just the sign bit inverted: no arithmetic needed.
  assign w_code = OFFSET_BINARY ? {~i_sample_in[DATA_W-1], i_sample_in[DATA_W-2:0]}
                                : i_sample_in;

  always_comb begin
    w_state_d = r_state;
    w_div_d   = r_div;
    w_bit_d   = r_bit;
    w_gap_d   = r_gap;
    w_shift_d = r_shift;
    w_sclk_d  = r_sclk;
    w_cs_n_d  = r_cs_n;
    w_busy_d  = r_busy;
    w_done_d  = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (i_tick) begin
          w_state_d = StShift;
          w_div_d   = '0;
          w_bit_d   = '0;
          w_shift_d = w_code;
          w_sclk_d  = 1'b0;
          w_cs_n_d  = 1'b0;
          w_busy_d  = 1'b1;
        end
      end
      StShift: begin
        if (r_div == DivLast) begin
          w_div_d  = '0;
          w_sclk_d = 1'b0;
          if (r_bit == BitLast) begin
            w_state_d = StGap;
            w_gap_d   = '0;
            w_shift_d = '0;
            w_cs_n_d  = 1'b1;
            w_done_d  = 1'b1;
          end else begin
            w_bit_d   = r_bit + 1'b1;
            w_shift_d = {r_shift[DATA_W-2:0], 1'b0};
          end
        end else begin
          w_div_d = r_div + 1'b1;
          if (r_div == DivHi) w_sclk_d = 1'b1;
        end
      end
      StGap: begin
        if (r_gap == GapLast) begin
          w_state_d = StIdle;
          w_busy_d  = 1'b0;
        end else begin
          w_gap_d = r_gap + 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase

    // A tick that collides with a clear while busy still flags the overrun.
    w_overrun_d = r_overrun;
    if (i_tick && (r_state != StIdle)) w_overrun_d = 1'b1;
    else if (i_clr_overrun)            w_overrun_d = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_div     <= '0;
      r_bit     <= '0;
      r_gap     <= '0;
      r_shift   <= '0;
      r_sclk    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_div     <= w_div_d;
      r_bit     <= w_bit_d;
      r_gap     <= w_gap_d;
      r_shift   <= w_shift_d;
      r_sclk    <= w_sclk_d;
      r_cs_n    <= w_cs_n_d;
      r_busy    <= w_busy_d;
      r_done    <= w_done_d;
      r_overrun <= w_overrun_d;
    end
  end

  assign o_sclk    = r_sclk;
  assign o_sdata   = r_shift[DATA_W-1];
  assign o_cs_n    = r_cs_n;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_overrun = r_overrun;

endmodule

// File: tb/tb_dac_spi_serializer.sv
// Bench for dac_spi_serializer: two instances (default and fast two's-complement) checked
// every cycle against a cycle-offset pin model, plus a DAC-side frame capture scoreboard.
module tb_dac_spi_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  tick = '0, clr = '0;
  logic [15:0] smp [2];
  logic [1:0]  sclk, sdata, cs_n, busy, done, ovr;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  // Model parameters for instance 0 (defaults) and instance 1 (fast, two's complement).
  int pd  [2] = '{2, 1};
  int pm  [2] = '{2, 1};
  bit pob [2] = '{1'b1, 1'b0};

  int          acc  [2] = '{-100000, -100000};
  logic [15:0] mcode[2] = '{16'h0, 16'h0};
  logic        mov  [2] = '{1'b0, 1'b0};
  logic [15:0] q0[$], q1[$];

  logic [15:0] w0 = '0, w1 = '0;
  int          c0 = 0, c1 = 0;

  always #5 clk = ~clk;

  dac_spi_serializer u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sample_in(smp[0]), .i_tick(tick[0]),
    .i_clr_overrun(clr[0]), .o_sclk(sclk[0]), .o_sdata(sdata[0]), .o_cs_n(cs_n[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_overrun(ovr[0])
  );

  dac_spi_serializer #(.SCLK_DIV(1), .MIN_CS_HIGH(1), .OFFSET_BINARY(1'b0)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sample_in(smp[1]), .i_tick(tick[1]),
    .i_clr_overrun(clr[1]), .o_sclk(sclk[1]), .o_sdata(sdata[1]), .o_cs_n(cs_n[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_overrun(ovr[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int frame_len(input int i);
    return 1 + 2 * pd[i] * 16 + pm[i];
  endfunction

  function automatic logic [15:0] to_code(input logic [15:0] s, input bit ob);
    return ob ? 16'(s + 16'h8000) : s;
  endfunction

  // {cs_n, sclk, sdata, busy, done} at k cycles after the accepting edge.
  function automatic logic [4:0] exp_pins(input int k, input int d, input int mch,
                                          input logic [15:0] code);
    int sl, b, ph;
    sl = 2 * d * 16;
    if (k >= 1 && k <= sl) begin
      b  = (k - 1) / (2 * d);
      ph = (k - 1) % (2 * d);
      return {1'b0, ph >= d, code[15-b], 1'b1, 1'b0};
    end
    if (k == sl + 1) return 5'b10011;
    if (k >= sl + 2 && k <= sl + mch) return 5'b10010;
    return 5'b10000;
  endfunction

  // DAC-side capture: shift in on sclk rise, judge the word when cs_n rises.
  always @(negedge cs_n[0]) begin w0 = '0; c0 = 0; end
  always @(negedge cs_n[1]) begin w1 = '0; c1 = 0; end
  always @(posedge sclk[0]) begin w0 = {w0[14:0], sdata[0]}; c0++; end
  always @(posedge sclk[1]) begin w1 = {w1[14:0], sdata[1]}; c1++; end

  always @(posedge cs_n[0]) begin
    if (mon_en && rst_n) begin
      check_eq("dac0_pending", q0.size(), 1);
      if (q0.size() > 0) check_eq("dac0_word", w0, q0.pop_front());
      check_eq("dac0_sclk_rises", c0, 16);
    end
  end

  always @(posedge cs_n[1]) begin
    if (mon_en && rst_n) begin
      check_eq("dac1_pending", q1.size(), 1);
      if (q1.size() > 0) check_eq("dac1_word", w1, q1.pop_front());
      check_eq("dac1_sclk_rises", c1, 16);
    end
  end

  // One clock cycle: drive at the negedge, update the model at the posedge, check at the next negedge.
  task automatic step(input logic [1:0] tk, input logic [1:0] cl,
                      input logic [15:0] s0, input logic [15:0] s1);
    bit idle;
    tick   = tk;
    clr    = cl;
    smp[0] = s0;
    smp[1] = s1;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst_n) begin
        idle = (cyc - acc[i]) >= frame_len(i);
        if (tk[i] && idle) begin
          acc[i]   = cyc;
          mcode[i] = to_code(i == 0 ? s0 : s1, pob[i]);
          if (i == 0) q0.push_back(mcode[i]);
          else        q1.push_back(mcode[i]);
        end
        if (tk[i] && !idle) mov[i] = 1'b1;
        else if (cl[i])     mov[i] = 1'b0;
      end
    end
    cyc++;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_eq(i == 0 ? "pins0" : "pins1",
               {26'd0, cs_n[i], sclk[i], sdata[i], busy[i], done[i], ovr[i]},
               {26'd0, exp_pins(cyc - acc[i], pd[i], pm[i], mcode[i]), mov[i]});
    end
  endtask

  task automatic idle_steps(input int n);
    for (int j = 0; j < n; j++) step(2'b00, 2'b00, 16'($urandom), 16'($urandom));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      acc[i] = -100000;
      mov[i] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  initial begin
    logic [15:0] ob_vec [3];
    ob_vec = '{16'h8000, 16'h7FFF, 16'h0000};
    smp[0] = '0;
    smp[1] = '0;

    // Reset state
    @(negedge clk);
    idle_steps(3);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle_steps(2);

    // Directed frames: 1234 -> 9234 offset binary; 8000 stays 8000 in two's complement
    step(2'b11, 2'b00, 16'h1234, 16'h8000);
    idle_steps(70);

    // Offset-binary corner codes, back to back at the minimum frame period
    for (int n = 0; n < 3; n++) begin
      step(2'b01, 2'b00, ob_vec[n], 16'($urandom));
      idle_steps(66);
    end
    idle_steps(2);

    // Overrun: ticks at cycles 30 and 66 ignored, cycle 67 accepted, then tick+clr, then clr
    step(2'b01, 2'b00, 16'hA5C3, 16'h0);
    idle_steps(29);
    step(2'b01, 2'b00, 16'h1111, 16'h0);
    idle_steps(35);
    step(2'b01, 2'b00, 16'h2222, 16'h0);
    step(2'b01, 2'b00, 16'h3C3C, 16'h0);
    idle_steps(5);
    step(2'b01, 2'b01, 16'h4444, 16'h0);
    idle_steps(3);
    step(2'b00, 2'b01, 16'h0, 16'h0);
    idle_steps(70);

    // Asynchronous reset in the middle of bit 5
    step(2'b01, 2'b00, 16'hBEEF, 16'h0);
    idle_steps(21);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_eq("async_reset_pins", {27'd0, cs_n[0], sclk[0], sdata[0], busy[0], done[0]},
                32'b10000);
    @(negedge clk);
    idle_steps(3);
    rst_n = 1'b1;
    idle_steps(5);

    // Streams: 128-cycle spacing on the default instance, exact frame period on the fast one
    for (int n = 0; n < 8 * 128; n++)
      step({n % 34 == 0, n % 128 == 0}, 2'b00, 16'($urandom), 16'($urandom));
    idle_steps(70);

    // Random ticks, clears and samples
    for (int n = 0; n < 3000; n++)
      step({$urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0},
           {$urandom_range(0, 49) == 0, $urandom_range(0, 49) == 0},
           16'($urandom), 16'($urandom));
    idle_steps(70);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
